fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage: owns the program counter and drives the byte address
//  of the instruction memory. Captures the 32-bit word returned combinationally
//  (big-endian, 4 bytes from A..A+3) into the IF/ID pipeline register for decode.
//  Supports a decode-side stall and a branch/jump redirect.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC value loaded on reset
//  IMEM_BYTES  256            instruction memory size in bytes; fetch beyond it flags error
//  NOP_INSTR   32'h0000_0000  word placed in id_instr when the slot is a bubble
// PORTS
//  clk          in   1   rising-edge clock
//  rst_n        in   1   asynchronous active-low reset
//  imem_addr    out  32  byte address to instruction memory (A); equals pc
//  imem_rdata   in   32  instruction word from memory (RD), valid same cycle
//  stall        in   1   1 = hold pc and IF/ID register unchanged
//  redirect     in   1   1 = branch/jump taken; load redirect_pc, squash slot
//  redirect_pc  in   32  redirect target byte address
//  pc           out  32  current fetch PC
//  id_instr     out  32  registered instruction to decode
//  id_pc        out  32  registered PC of id_instr
//  id_valid     out  1   id_instr is a real instruction (0 = bubble)
//  id_err       out  1   id_instr slot came from a misaligned/out-of-range fetch
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-low. While rst_n=0: pc=RESET_PC,
//    id_instr=NOP_INSTR, id_pc=0, id_valid=0, id_err=0; takes effect immediately.
//  - imem_addr is combinationally pc; no other combinational path to outputs.
//  - Priority each rising edge: redirect > stall > advance.
//  - Advance (redirect=0, stall=0): id_instr<=imem_rdata, id_pc<=pc, id_valid<=1,
//    id_err<=fetch_bad, pc<=pc+4 (32-bit, wraps 32'hFFFF_FFFC -> 0).
//  - Stall (redirect=0, stall=1): pc, id_instr, id_pc, id_valid, id_err all hold.
//  - Redirect (redirect=1, stall ignored): pc<={redirect_pc[31:2],2'b00};
//    id_instr<=NOP_INSTR, id_pc<=pc, id_valid<=0, id_err<=0 (wrong-path word
//    fetched this cycle is squashed). Target's low 2 bits are dropped silently.
//  - fetch_bad = (pc[1:0]!=0) | (pc > IMEM_BYTES-4). When fetch_bad, the slot is
//    still issued with id_valid=1, id_err=1 and id_instr=NOP_INSTR (rdata ignored);
//    pc still advances by 4. Misalignment is only reachable via RESET_PC.
//  - Latency: word at address X appears on id_instr one edge after pc==X with no
//    stall/redirect. Steady state: one instruction per cycle.
//  - Back-to-back redirects: each one loads its own target; every cycle squashed.
//  - Reset asserted mid-stall or mid-redirect: reset wins, no partial update.
//  - First edge after rst_n rises fetches RESET_PC; id_valid=0 until that edge.
// TESTING
//  1 Reset: rst_n=0 asynchronously mid-cycle -> pc=0, id_valid=0, id_instr=0 at once.
//  2 Sequential: mem bytes 0..7 = 12 34 56 78 9A BC DE F0, 2 edges -> id_instr
//    32'h12345678/id_pc 0, then 32'h9ABCDEF0/id_pc 4; pc=8, id_valid=1 both.
//  3 Stall: stall=1 for 3 edges at pc=8 -> pc=8, id_instr/id_pc/id_valid unchanged;
//    release -> next edge id_pc=8.
//  4 Redirect: redirect=1, redirect_pc=32'h43, stall=1 same edge -> pc=32'h40,
//    id_valid=0, id_instr=NOP; next edge id_pc=32'h40, id_valid=1.
//  5 Range: pc reaches 252 -> id_err=0; next edge (pc=256 fetched) -> id_err=1,
//    id_valid=1, id_instr=NOP_INSTR, pc=260.
//  6 Wrap: RESET_PC=32'hFFFF_FFFC, IMEM_BYTES=256 -> after one edge pc=0, id_err=1.

Source files
------------

// File: rtl/fetch_if.sv
// Fetch-stage bus: instruction-memory port, decode-side controls and the IF/ID register outputs.
interface fetch_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pc;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_valid;
  logic        id_err;

  modport master (
    input  imem_rdata, stall, redirect, redirect_pc,
    output imem_addr, pc, id_instr, id_pc, id_valid, id_err
  );

  modport slave (
    output imem_rdata, stall, redirect, redirect_pc,
    input  imem_addr, pc, id_instr, id_pc, id_valid, id_err
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the instruction memory and
// loads the IF/ID register with priority redirect > stall > advance.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 256,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
  input logic     clk,
  input logic     rst_n,
  fetch_if.master bus
);

  localparam int unsigned W_ADDR    = 32;
  localparam logic [31:0] LAST_ADDR = W_ADDR'(IMEM_BYTES - 4);

  logic [31:0] r_pc;
  logic [31:0] r_id_instr;
  logic [31:0] r_id_pc;
  logic        r_id_valid;
  logic        r_id_err;

  logic [31:0] w_pc_next;
  logic [31:0] w_id_instr_next;
  logic [31:0] w_id_pc_next;
  logic        w_id_valid_next;
  logic        w_id_err_next;
  logic        w_fetch_bad;

  // Misaligned or past the last full word: slot issues as a flagged NOP.
  assign w_fetch_bad = (r_pc[1:0] != 2'b00) || (r_pc > LAST_ADDR);

  always_comb begin
    w_pc_next       = r_pc;
    w_id_instr_next = r_id_instr;
    w_id_pc_next    = r_id_pc;
    w_id_valid_next = r_id_valid;
    w_id_err_next   = r_id_err;
    if (bus.redirect) begin
      w_pc_next       = {bus.redirect_pc[31:2], 2'b00};
      w_id_instr_next = NOP_INSTR;
      w_id_pc_next    = r_pc;
      w_id_valid_next = 1'b0;
      w_id_err_next   = 1'b0;
    end else if (!bus.stall) begin
      w_pc_next       = r_pc + W_ADDR'(4);
      w_id_instr_next = w_fetch_bad ? NOP_INSTR : bus.imem_rdata;
      w_id_pc_next    = r_pc;
      w_id_valid_next = 1'b1;
      w_id_err_next   = w_fetch_bad;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_id_instr <= NOP_INSTR;
      r_id_pc    <= '0;
      r_id_valid <= 1'b0;
      r_id_err   <= 1'b0;
    end else begin
      r_pc       <= w_pc_next;
      r_id_instr <= w_id_instr_next;
      r_id_pc    <= w_id_pc_next;
      r_id_valid <= w_id_valid_next;
      r_id_err   <= w_id_err_next;
    end
  end

  assign bus.imem_addr = r_pc;
  assign bus.pc        = r_pc;
  assign bus.id_instr  = r_id_instr;
  assign bus.id_pc     = r_id_pc;
  assign bus.id_valid  = r_id_valid;
  assign bus.id_err    = r_id_err;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed steps push expected state, a monitor pops and compares.
module tb_fetch_stage;

  logic clk;
  logic rst_n;

  fetch_if bus1 ();
  fetch_if bus2 ();

  fetch_stage #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_BYTES (256),
    .NOP_INSTR  (32'h0000_0000)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  fetch_stage #(
    .RESET_PC   (32'hFFFF_FFFC),
    .IMEM_BYTES (256),
    .NOP_INSTR  (32'h0000_0000)
  ) u_dut_wrap (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [0:255];

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [7:0] b;
    if (a > 32'd252) return 32'hBAD0_BAD0;
    b = a[7:0];
    return {mem[b], mem[8'(b + 8'd1)], mem[8'(b + 8'd2)], mem[8'(b + 8'd3)]};
  endfunction

  always_comb bus1.imem_rdata = word_at(bus1.imem_addr);
  assign bus2.imem_rdata   = 32'hCAFE_F00D;
  assign bus2.stall        = 1'b0;
  assign bus2.redirect     = 1'b0;
  assign bus2.redirect_pc  = 32'h0;

  typedef struct {
    string       name;
    logic [31:0] pc, instr, id_pc;
    logic        valid, err;
    logic        has2;
    logic [31:0] pc2, instr2, id_pc2;
    logic        valid2, err2;
  } exp_t;

  exp_t q[$];
  event ev_async;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Monitor: one pop after every clock edge, or on demand for asynchronous checks.
  initial begin
    exp_t        e;
    logic [97:0] act, exv;
    forever begin
      @(posedge clk or ev_async);
      #1;
      if (q.size() > 0) begin
        e   = q.pop_front();
        act = {bus1.pc, bus1.id_instr, bus1.id_pc, bus1.id_valid, bus1.id_err};
        exv = {e.pc, e.instr, e.id_pc, e.valid, e.err};
        n_cmp++;
        if (act !== exv) begin
          n_bad++;
          $display("FAIL %s: got pc=%h instr=%h id_pc=%h v=%b e=%b want pc=%h instr=%h id_pc=%h v=%b e=%b",
                   e.name, bus1.pc, bus1.id_instr, bus1.id_pc, bus1.id_valid, bus1.id_err,
                   e.pc, e.instr, e.id_pc, e.valid, e.err);
        end
        if (e.has2) begin
          act = {bus2.pc, bus2.id_instr, bus2.id_pc, bus2.id_valid, bus2.id_err};
          exv = {e.pc2, e.instr2, e.id_pc2, e.valid2, e.err2};
          n_cmp++;
          if (act !== exv) begin
            n_bad++;
            $display("FAIL %s_wrap: got pc=%h instr=%h id_pc=%h v=%b e=%b want pc=%h instr=%h id_pc=%h v=%b e=%b",
                     e.name, bus2.pc, bus2.id_instr, bus2.id_pc, bus2.id_valid, bus2.id_err,
                     e.pc2, e.instr2, e.id_pc2, e.valid2, e.err2);
          end
        end
      end
    end
  end

  function automatic exp_t mk(input string nm, input logic [31:0] p, ins, ip,
                              input logic v, er);
    exp_t e;
    e.name = nm; e.pc = p; e.instr = ins; e.id_pc = ip; e.valid = v; e.err = er;
    e.has2 = 1'b0; e.pc2 = '0; e.instr2 = '0; e.id_pc2 = '0; e.valid2 = 1'b0; e.err2 = 1'b0;
    return e;
  endfunction

  // Called at a falling edge: drive inputs, queue the state expected after the next rising edge.
  task automatic step(input string nm, input logic st, rd, input logic [31:0] rpc,
                      input logic [31:0] p, ins, ip, input logic v, er, input logic c2);
    exp_t e;
    bus1.stall       = st;
    bus1.redirect    = rd;
    bus1.redirect_pc = rpc;
    e = mk(nm, p, ins, ip, v, er);
    if (c2) begin
      e.has2 = 1'b1; e.pc2 = 32'h0; e.instr2 = 32'h0; e.id_pc2 = 32'hFFFF_FFFC;
      e.valid2 = 1'b1; e.err2 = 1'b1;
    end
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Mid-cycle check of reset state, optionally asserting reset right here.
  task automatic async_chk(input string nm, input logic assert_rst);
    exp_t e;
    #2;
    if (assert_rst) rst_n = 1'b0;
    e = mk(nm, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    e.has2 = 1'b1; e.pc2 = 32'hFFFF_FFFC;
    q.push_back(e);
    -> ev_async;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
    mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56; mem[3] = 8'h78;
    mem[4] = 8'h9A; mem[5] = 8'hBC; mem[6] = 8'hDE; mem[7] = 8'hF0;
    rst_n = 1'b0;
    bus1.stall = 1'b0; bus1.redirect = 1'b0; bus1.redirect_pc = 32'h0;

    repeat (2) @(negedge clk);
    async_chk("rst_init", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    async_chk("post_release", 1'b0);

    step("seq0", 0, 0, 0, 32'h8 - 32'h4, 32'h1234_5678, 32'h0, 1, 0, 1);
    step("seq1", 0, 0, 0, 32'h8, 32'h9ABC_DEF0, 32'h4, 1, 0, 0);
    for (int i = 0; i < 3; i++)
      step("stall_hold", 1, 0, 0, 32'h8, 32'h9ABC_DEF0, 32'h4, 1, 0, 0);
    step("stall_release", 0, 0, 0, 32'hC, word_at(32'h8), 32'h8, 1, 0, 0);

    step("redir_stall", 1, 1, 32'h43, 32'h40, 32'h0, 32'hC, 0, 0, 0);
    step("redir_target", 0, 0, 0, 32'h44, word_at(32'h40), 32'h40, 1, 0, 0);
    step("redir_b2b_a", 0, 1, 32'h80, 32'h80, 32'h0, 32'h44, 0, 0, 0);
    step("redir_b2b_b", 0, 1, 32'hF5, 32'hF4, 32'h0, 32'h80, 0, 0, 0);

    step("range_f4", 0, 0, 0, 32'hF8, word_at(32'hF4), 32'hF4, 1, 0, 0);
    step("range_f8", 0, 0, 0, 32'hFC, word_at(32'hF8), 32'hF8, 1, 0, 0);
    step("range_252", 0, 0, 0, 32'h100, word_at(32'hFC), 32'hFC, 1, 0, 0);
    step("range_256", 0, 0, 0, 32'h104, 32'h0, 32'h100, 1, 1, 0);
    step("range_260", 0, 0, 0, 32'h108, 32'h0, 32'h104, 1, 1, 0);
    step("err_stall", 1, 0, 0, 32'h108, 32'h0, 32'h104, 1, 1, 0);
    step("redir_clr_err", 0, 1, 32'h0, 32'h0, 32'h0, 32'h108, 0, 0, 0);
    step("refetch0", 0, 0, 0, 32'h4, 32'h1234_5678, 32'h0, 1, 0, 0);

    bus1.stall = 1'b1; bus1.redirect = 1'b1; bus1.redirect_pc = 32'h80;
    async_chk("rst_mid_cycle", 1'b1);
    step("rst_beats_redir", 1, 1, 32'h80, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    rst_n = 1'b1;
    step("after_rst0", 0, 0, 0, 32'h4, 32'h1234_5678, 32'h0, 1, 0, 0);
    step("after_rst1", 0, 0, 0, 32'h8, 32'h9ABC_DEF0, 32'h4, 1, 0, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
